// File: rtl/bsg_link_arb_pkg.sv
// Shared geometry helpers and flit layout for the link channel arbiter.
// The flit is {channel id, payload}; the id sits in the upper bits.
package bsg_link_arb_pkg;

    localparam int def_num_in_lp      = 4;
    localparam int def_payload_width_lp = 62;

    function automatic int id_width(input int num_in);
        return (num_in <= 1) ? 1 : $clog2(num_in);
    endfunction

    function automatic int credit_width(input int credit_max);
        return $clog2(credit_max + 1);
    endfunction

    // Flit view for the default geometry. The top declares its own copy sized from its parameters.
    typedef struct packed {
        logic [id_width(def_num_in_lp)-1:0] id;
        logic [def_payload_width_lp-1:0]    payload;
    } bsg_link_flit_t;

endpackage

// File: rtl/bsg_link_rr_arb.sv
// Round-robin arbiter: the first requester at or above the pointer wins.
// The pointer moves to winner+1 only when a grant is issued.
module bsg_link_rr_arb
    import bsg_link_arb_pkg::*;
#(
    parameter int num_in_p    = 4,
    parameter int id_width_lp = id_width(num_in_p)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [num_in_p-1:0]    req_i,
    input  logic                   en_i,
    output logic [num_in_p-1:0]    grant_o,
    output logic [id_width_lp-1:0] grant_id_o
);

    logic [id_width_lp-1:0] ptr_q, ptr_d;
    logic [id_width_lp-1:0] win_id;
    logic [id_width_lp-1:0] idx;
    logic                   found;
    int                     k;

    always_comb begin
        win_id = '0;
        found  = 1'b0;
        idx    = '0;
        k      = 0;
        for (int off = 0; off < num_in_p; off++) begin
            k = int'(ptr_q) + off;
            if (k >= num_in_p) k = k - num_in_p;
            idx = id_width_lp'(k);
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
    end

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        if (en_i && found) begin
            grant_o = {{(num_in_p-1){1'b0}}, 1'b1} << win_id;
            ptr_d   = (win_id == id_width_lp'(num_in_p - 1)) ? '0 : win_id + 1'b1;
        end
    end

    assign grant_id_o = win_id;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bsg_link_channel_arbiter.sv
// Shares one upstream core-side link channel among num_in_p requesters,
// with round-robin arbitration, per-channel far-end credits and id tagging.
module bsg_link_channel_arbiter
    import bsg_link_arb_pkg::*;
#(
    parameter int num_in_p        = 4,
    parameter int payload_width_p = 62,
    parameter int credit_max_p    = 8,
    localparam int id_width_lp     = id_width(num_in_p),
    localparam int credit_width_lp = credit_width(credit_max_p)
) (
    input  logic                                  core_clk_i,
    input  logic                                  core_link_reset_n_i,
    input  logic                                  en_i,
    input  logic [num_in_p*payload_width_p-1:0]   req_data_i,
    input  logic [num_in_p-1:0]                   req_v_i,
    output logic [num_in_p-1:0]                   req_yumi_o,
    output logic [id_width_lp+payload_width_p-1:0] link_data_o,
    output logic                                  link_v_o,
    input  logic                                  link_ready_i,
    input  logic                                  credit_v_i,
    input  logic [id_width_lp-1:0]                credit_id_i,
    output logic [num_in_p*credit_width_lp-1:0]   credit_cnt_o,
    output logic                                  overflow_o
);

    typedef struct packed {
        logic [id_width_lp-1:0]     id;
        logic [payload_width_p-1:0] payload;
    } flit_t;

    // Handshake: the output flit moves when link_v_o & link_ready_i; while valid and
    // not ready it holds steady. A requester's payload is consumed in the cycle its
    // req_yumi_o bit is high, and it must hold req_v_i/req_data_i until then.
    flit_t                      flit_q, flit_d;
    logic                       link_v_q, link_v_d;
    logic [credit_width_lp-1:0] credit_q [num_in_p];
    logic [credit_width_lp-1:0] credit_d [num_in_p];
    logic                       overflow_q, overflow_d;

    logic [num_in_p-1:0]        eligible;
    logic [num_in_p-1:0]        grant;
    logic [id_width_lp-1:0]     grant_id;
    logic                       arb_en;
    logic                       grant_v;
    logic [payload_width_p-1:0] payload_sel;
    logic                       ret_in_range;

    always_comb begin
        for (int i = 0; i < num_in_p; i++) begin
            eligible[i] = req_v_i[i] && (credit_q[i] != '0);
        end
    end

    // Gating on reset keeps yumi low while the block is held in reset.
    assign arb_en = en_i && (!link_v_q || link_ready_i) && core_link_reset_n_i;

    bsg_link_rr_arb #(
        .num_in_p    (num_in_p),
        .id_width_lp (id_width_lp)
    ) u_rr_arb (
        .clk_i      (core_clk_i),
        .rst_n_i    (core_link_reset_n_i),
        .req_i      (eligible),
        .en_i       (arb_en),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign grant_v    = |grant;
    assign req_yumi_o = grant;

    always_comb begin
        payload_sel = '0;
        for (int i = 0; i < num_in_p; i++) begin
            if (grant_id == id_width_lp'(i)) payload_sel = req_data_i[i*payload_width_p +: payload_width_p];
        end
    end

    always_comb begin
        flit_d   = flit_q;
        link_v_d = link_v_q;
        if (grant_v) begin
            flit_d.id      = grant_id;
            flit_d.payload = payload_sel;
            link_v_d       = 1'b1;
        end else if (link_ready_i) begin
            link_v_d = 1'b0;
        end
    end

    assign ret_in_range = (32'(credit_id_i) < num_in_p);

    // A grant only happens on a nonzero counter, so decrement never wraps.
    always_comb begin
        overflow_d = overflow_q;
        if (credit_v_i && !ret_in_range) overflow_d = 1'b1;
        for (int i = 0; i < num_in_p; i++) begin
            credit_d[i] = credit_q[i];
            if (credit_v_i && ret_in_range && credit_id_i == id_width_lp'(i)) begin
                if (!grant[i]) begin
                    if (credit_q[i] == credit_width_lp'(credit_max_p)) overflow_d = 1'b1;
                    else credit_d[i] = credit_q[i] + 1'b1;
                end
            end else if (grant[i]) begin
                credit_d[i] = credit_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge core_clk_i or negedge core_link_reset_n_i) begin
        if (!core_link_reset_n_i) begin
            flit_q     <= '0;
            link_v_q   <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < num_in_p; i++) credit_q[i] <= credit_width_lp'(credit_max_p);
        end else begin
            flit_q     <= flit_d;
            link_v_q   <= link_v_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < num_in_p; i++) credit_q[i] <= credit_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < num_in_p; i++) begin
            credit_cnt_o[i*credit_width_lp +: credit_width_lp] = credit_q[i];
        end
    end

    assign link_data_o = flit_q;
    assign link_v_o    = link_v_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_bsg_link_channel_arbiter.sv
// Directed bench for bsg_link_channel_arbiter: a vector table for round-robin,
// backpressure and enable behaviour, plus hand sequences for credits and reset.
module tb_bsg_link_channel_arbiter;

    localparam int N  = 4;
    localparam int PW = 62;
    localparam int IW = 2;
    localparam int CW = 4;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [N*PW-1:0] req_data;
    logic [N-1:0]    req_v;
    logic [N-1:0]    yumi;
    logic [IW+PW-1:0] link_data;
    logic            link_v;
    logic            ready;
    logic            credit_v;
    logic [IW-1:0]   credit_id;
    logic [N*CW-1:0] credit_cnt;
    logic            overflow;

    int tests_run;
    int tests_failed;

    bsg_link_channel_arbiter #(
        .num_in_p        (N),
        .payload_width_p (PW),
        .credit_max_p    (8)
    ) dut (
        .core_clk_i          (clk),
        .core_link_reset_n_i (rst_n),
        .en_i                (en),
        .req_data_i          (req_data),
        .req_v_i             (req_v),
        .req_yumi_o          (yumi),
        .link_data_o         (link_data),
        .link_v_o            (link_v),
        .link_ready_i        (ready),
        .credit_v_i          (credit_v),
        .credit_id_i         (credit_id),
        .credit_cnt_o        (credit_cnt),
        .overflow_o          (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [N-1:0] req;
        logic         rdy;
        logic [N-1:0] exp_yumi;
        logic         exp_v;
        int           exp_id;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [PW-1:0] payload_of(input int i);
        return {30'(i + 1), 32'hDEAD_0000 | 32'(i)};
    endfunction

    function automatic logic [IW+PW-1:0] flit_of(input int i);
        return {IW'(i), payload_of(i)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] cred(input int i);
        return credit_cnt[i*CW +: CW];
    endfunction

    task automatic add(input logic e, input logic [N-1:0] r, input logic rd,
                       input logic [N-1:0] y, input logic v, input int id);
        vec_t t;
        t.en = e; t.req = r; t.rdy = rd; t.exp_yumi = y; t.exp_v = v; t.exp_id = id;
        vecs.push_back(t);
    endtask

    int cnt;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        en        = 1'b1;
        req_v     = 4'hF;
        ready     = 1'b1;
        credit_v  = 1'b0;
        credit_id = '0;
        for (int i = 0; i < N; i++) req_data[i*PW +: PW] = payload_of(i);

        // Round robin at full rate: grants 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) add(1, 4'hF, 1, 4'(1 << (k % 4)), 1, k % 4);
        // Backpressure holds flit 3, then ready drains it and reloads channel 0.
        for (int k = 0; k < 5; k++) add(1, 4'hF, 0, 4'h0, 1, 3);
        add(1, 4'hF, 1, 4'h1, 1, 0);
        add(1, 4'h0, 1, 4'h0, 0, 0);
        // Enable drop: held flit drains, no grants, pointer frozen at 2.
        add(1, 4'hF, 1, 4'h2, 1, 1);
        add(0, 4'hF, 0, 4'h0, 1, 1);
        add(0, 4'hF, 1, 4'h0, 0, 0);
        add(0, 4'hF, 1, 4'h0, 0, 0);
        add(1, 4'hF, 1, 4'h4, 1, 2);
        add(1, 4'h0, 1, 4'h0, 0, 0);

        // Reset state, with requests active so yumi gating is exercised.
        @(posedge clk); #1;
        check("rst_yumi", 64'(yumi), 64'h0);
        @(posedge clk); #1;
        check("rst_link_v", 64'(link_v), 64'h0);
        check("rst_link_data", 64'(link_data), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        for (int i = 0; i < N; i++) check($sformatf("rst_credit%0d", i), 64'(cred(i)), 64'd8);
        #2 rst_n = 1'b1;
        req_v = 4'h0;
        tick();

        foreach (vecs[r]) begin
            en    = vecs[r].en;
            req_v = vecs[r].req;
            ready = vecs[r].rdy;
            #1;
            check($sformatf("vec%0d_yumi", r), 64'(yumi), 64'(vecs[r].exp_yumi));
            tick();
            check($sformatf("vec%0d_link_v", r), 64'(link_v), 64'(vecs[r].exp_v));
            if (vecs[r].exp_v) check($sformatf("vec%0d_data", r), 64'(link_data), 64'(flit_of(vecs[r].exp_id)));
        end
        en = 1'b1;
        check("tbl_credit0", 64'(cred(0)), 64'd5);
        check("tbl_credit1", 64'(cred(1)), 64'd5);
        check("tbl_credit2", 64'(cred(2)), 64'd5);
        check("tbl_credit3", 64'(cred(3)), 64'd6);

        // Mid-stream reset: pointer is at 3, so grants go 3,0,1.
        req_v = 4'hF;
        ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("pre_rst_link_v", 64'(link_v), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_link_v", 64'(link_v), 64'h0);
        check("mid_rst_yumi", 64'(yumi), 64'h0);
        for (int i = 0; i < N; i++) check($sformatf("mid_rst_credit%0d", i), 64'(cred(i)), 64'd8);
        #2 rst_n = 1'b1;
        #1;
        check("post_rst_yumi", 64'(yumi), 64'h1);
        tick();
        check("post_rst_data", 64'(link_data), 64'(flit_of(0)));

        // Channel 2 alone exhausts its 8 credits.
        req_v = 4'h4;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (yumi == 4'h4) cnt++;
            tick();
        end
        check("ch2_flit_count", 64'(cnt), 64'd8);
        check("ch2_credit_zero", 64'(cred(2)), 64'd0);
        check("ch2_yumi_starved", 64'(yumi), 64'h0);
        check("ch2_link_idle", 64'(link_v), 64'h0);
        credit_v  = 1'b1;
        credit_id = 2'd2;
        #1;
        check("ch2_yumi_on_return", 64'(yumi), 64'h0);
        tick();
        credit_v = 1'b0;
        #1;
        check("ch2_yumi_after_return", 64'(yumi), 64'h4);
        tick();
        check("ch2_ninth_v", 64'(link_v), 64'h1);
        check("ch2_ninth_data", 64'(link_data), 64'(flit_of(2)));
        check("ch2_credit_after", 64'(cred(2)), 64'd0);

        // Channel 1 down to 3 credits, then grant and return coincide.
        req_v = 4'h2;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("ch1_yumi%0d", k), 64'(yumi), 64'h2);
            tick();
        end
        req_v = 4'h0;
        tick();
        check("ch1_credit3", 64'(cred(1)), 64'd3);
        req_v     = 4'h2;
        credit_v  = 1'b1;
        credit_id = 2'd1;
        #1;
        check("ch1_coincide_yumi", 64'(yumi), 64'h2);
        tick();
        req_v    = 4'h0;
        credit_v = 1'b0;
        check("ch1_coincide_credit", 64'(cred(1)), 64'd3);
        check("ch1_no_overflow", 64'(overflow), 64'h0);

        // Channel 0 sits at 7: first return fills it, second overflows.
        credit_v  = 1'b1;
        credit_id = 2'd0;
        tick();
        check("ch0_fill_credit", 64'(cred(0)), 64'd8);
        check("ch0_fill_overflow", 64'(overflow), 64'h0);
        tick();
        credit_v = 1'b0;
        check("ch0_over_credit", 64'(cred(0)), 64'd8);
        check("ch0_over_flag", 64'(overflow), 64'h1);
        tick();
        check("overflow_sticky", 64'(overflow), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bsg_link_channel_arbiter.md
Name: bsg_link_channel_arbiter

Overview:
Shares one bsg_link_ddr_upstream core-side channel between num_in_p independent requesters.
- Arbitration is round-robin.
- Each requester has a per-channel credit counter that models buffering at the far end.
- The granted requester's channel ID is prepended to its payload.
- Sits in the core clock domain, directly in front of the upstream core_data_i/core_valid_i/core_ready_o interface.

Parameters:
- num_in_p, 4, number of requester channels (2..8).
- payload_width_p, 62, per-requester payload bits.
- id_width_lp, $clog2(num_in_p), local; channel tag width.
- credit_max_p, 8, initial and maximum credits per channel (1..255).
- credit_width_lp, $clog2(credit_max_p+1), local; counter width.

Ports:
- core_clk_i  in  1  core clock; all logic on rising edge.
- core_link_reset_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  grant enable; 0 blocks new grants.
- req_data_i  in  num_in_p*payload_width_p  requester payloads, channel i at slice i.
- req_v_i  in  num_in_p  requester valid.
- req_yumi_o  out  num_in_p  one-hot (or zero) consume strobe; payload taken this cycle.
- link_data_o  out  id_width_lp+payload_width_p  {id, payload}; drives upstream core_data_i.
- link_v_o  out  1  output valid.
- link_ready_i  in  1  upstream core_ready_o.
- credit_v_i  in  1  one credit returned this cycle.
- credit_id_i  in  id_width_lp  channel receiving the returned credit.
- credit_cnt_o  out  num_in_p*credit_width_lp  current credit counts.
- overflow_o  out  1  sticky error: credit returned to a full counter, or credit_id_i >= num_in_p.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - link_v_o=0, link_data_o=0, req_yumi_o=0.
  - All credits = credit_max_p.
  - Round-robin pointer = 0 (channel 0 highest priority).
  - overflow_o=0.
- Output register (one entry):
  - Transfer occurs when link_v_o & link_ready_i.
  - link_data_o and link_v_o are stable while link_v_o=1 and link_ready_i=0.
- Eligibility: channel i is eligible iff req_v_i[i] & credit[i]!=0.
- Grant condition: en_i & (link_v_o==0 | link_ready_i) & at least one channel eligible. When met:
  - Winner = first eligible channel at or above the pointer, wrapping modulo num_in_p.
  - req_yumi_o[winner]=1 combinationally in the same cycle.
  - Next edge: link_data_o={winner, slice}, link_v_o=1, credit[winner]-=1, pointer=(winner+1) mod num_in_p.
- No grant while the output is full: when transfer and grant coincide, the output reloads back-to-back, giving 1 flit/cycle sustained.
- When transfer occurs without a grant, link_v_o clears next edge.
- Latency: req_v_i with empty output and credit available -> link_v_o high on the next edge (1 cycle).
- req_yumi_o is never asserted without a grant.
  - Requesters must hold req_data_i/req_v_i until yumi.
  - A requester deasserting valid without yumi is legal; it simply loses eligibility.
- Credit update per channel: next = cur - grant_hit + return_hit.
  - Simultaneous grant and return on the same channel leaves the count unchanged.
  - A return to a counter at credit_max_p with no same-cycle grant is dropped and sets overflow_o.
  - credit_id_i >= num_in_p is ignored and sets overflow_o.
  - Counters never wrap.
- en_i=0:
  - No new grants and the pointer is frozen.
  - A held output flit still drains.
  - Credit returns still apply.
- Pointer advances only on grant; an idle cycle does not move it.
- overflow_o clears only on reset.
- Reset mid-operation:
  - A pending output flit is discarded.
  - Credits are restored to max.
  - Downstream state must be reset in the same reset event; this is the system's responsibility.

Decomposition:
- Package bsg_link_arb_pkg holds:
  - the {id, payload} flit struct typedef;
  - localparam functions for id_width and credit_width.
- Sub-module bsg_link_rr_arb, a parameterised round-robin arbiter:
  - inputs: req vector, enable;
  - outputs: one-hot grant, grant index;
  - internal pointer advance on grant.
- The top block contains the output register, credit counters and overflow flag.

Test Plan:
1. num_in_p=4, all req_v_i=1, link_ready_i=1, en_i=1 -> grants 0,1,2,3,0,...; link_data_o ID field cycles 0..3; one flit per cycle after a first-flit latency of 1.
2. Only channel 2 requesting, no credit returns, credit_max_p=8 -> exactly 8 flits issued, credit_cnt[2] reaches 0, req_yumi_o[2] stays low; one credit_v_i with id=2 -> a 9th flit is issued the following cycle.
3. link_ready_i=0 for 5 cycles with link_v_o=1 -> link_data_o unchanged, req_yumi_o all zero; on ready -> flit transfers and the next grant loads in the same cycle.
4. Channel 1 granted in the same cycle as credit_v_i with id=1 and credit[1]=3 -> credit[1] stays 3; a return to a full counter -> overflow_o=1 and the count stays credit_max_p.
5. en_i dropped while a flit is held -> the flit drains, then link_v_o=0 and no yumi; en_i raised -> arbitration resumes from the frozen pointer.
6. core_link_reset_n_i asserted mid-stream with link_v_o=1 and credits partially used -> immediately link_v_o=0 and all credits=8; after release the first grant goes to channel 0.
